// File: rtl/bus_demux85.sv
// bus_demux85: bus-side responder for the 8085 multiplexed AD bus.
// Latches the 16-bit address on ALE, follows the read/write machine cycle,
// inserts WAIT wait-state clocks through ready, returns read data on the AD
// bus and issues a one-clock write strobe carrying the captured write data.
//
// Optional feature, enabled by defining DEMUX_IO_MIRROR_EN: on IO cycles the
// port number on ad_in is mirrored into both address bytes, and a mismatch
// between a_hi and ad_in at ALE raises a one-clock err pulse.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   ad_in, a_hi        AD[7:0] and A15..A8 sampled from the pins
//   ale, rd_n, wr_n    bus control strobes (ale high, rd_n/wr_n low active)
//   iom                IO/M, 1 = IO cycle
//   rdata              read data from the fabric, valid while rd_req=1
//   ad_out, ad_oe      data and output enable toward the AD pins
//   ready              8085 READY, combinational from state and wait counter
//   addr, addr_io      latched address and IO/M of the current cycle
//   rd_req             fabric read request
//   wdata, wr_stb      captured write data and one-clock write strobe
//   err                one-clock protocol error pulse
module bus_demux85 #(
    parameter int unsigned WAIT = 0,
    parameter int unsigned CW   = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [7:0]    ad_in,
    input  logic [7:0]    a_hi,
    input  logic          ale,
    input  logic          rd_n,
    input  logic          wr_n,
    input  logic          iom,
    input  logic [7:0]    rdata,
    output logic [7:0]    ad_out,
    output logic          ad_oe,
    output logic          ready,
    output logic [15:0]   addr,
    output logic          addr_io,
    output logic          rd_req,
    output logic [7:0]    wdata,
    output logic          wr_stb,
    output logic          err
);

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   ad_out_d;
    logic            ad_oe_d;
    logic [AW-1:0]   addr_d;
    logic            addr_io_d;
    logic            rd_req_d;
    logic [DW-1:0]   wdata_d;
    logic            wr_stb_d;
    logic            err_d;

    // Wait states are inserted only while a data phase still has count left.
    assign ready = !(((state_q == RD) || (state_q == WR)) && (cnt_q != '0));

    // Next-state and next-output decode; ALE overrides whatever phase is active.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ad_out_d  = ad_out;
        ad_oe_d   = ad_oe;
        addr_d    = addr;
        addr_io_d = addr_io;
        rd_req_d  = rd_req;
        wdata_d   = wdata;
        wr_stb_d  = 1'b0;
        err_d     = 1'b0;

        if (ale) begin
            addr_d    = {a_hi, ad_in};
            addr_io_d = iom;
            cnt_d     = CW'(WAIT);
            state_d   = ADDR;
            ad_oe_d   = 1'b0;
            rd_req_d  = 1'b0;
`ifdef DEMUX_IO_MIRROR_EN
            // IO port number appears on both address bytes of a real 8085.
            if (iom) begin
                addr_d = {ad_in, ad_in};
                err_d  = (a_hi != ad_in);
            end
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // Strobes without a preceding ALE are ignored.
                end
                ADDR: begin
                    if (!rd_n && !wr_n) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (!rd_n) begin
                        state_d  = RD;
                        rd_req_d = 1'b1;
                    end else if (!wr_n) begin
                        state_d = WR;
                    end
                end
                RD: begin
                    if (rd_n) begin
                        state_d  = IDLE;
                        ad_oe_d  = 1'b0;
                        rd_req_d = 1'b0;
                    end else if (cnt_q != '0) begin
                        cnt_d   = cnt_q - CW'(1);
                        ad_oe_d = 1'b0;
                    end else begin
                        ad_oe_d  = 1'b1;
                        ad_out_d = rdata;
                    end
                end
                WR: begin
                    if (wr_n) begin
                        wr_stb_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        wdata_d = ad_in;
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ad_out  <= '0;
            ad_oe   <= 1'b0;
            addr    <= '0;
            addr_io <= 1'b0;
            rd_req  <= 1'b0;
            wdata   <= '0;
            wr_stb  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ad_out  <= ad_out_d;
            ad_oe   <= ad_oe_d;
            addr    <= addr_d;
            addr_io <= addr_io_d;
            rd_req  <= rd_req_d;
            wdata   <= wdata_d;
            wr_stb  <= wr_stb_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_bus_demux85.sv
// Bench for bus_demux85: two instances (WAIT=0 and WAIT=2) share one stimulus
// stream; a transaction-level model tracks each bus cycle by phase and age.
module tb_bus_demux85;

    logic        clk;
    logic        rstn;
    logic [7:0]  ad_in;
    logic [7:0]  a_hi;
    logic        ale;
    logic        rd_n;
    logic        wr_n;
    logic        iom;
    logic [7:0]  rdata;

    logic [7:0]  ad_out_w  [2];
    logic        ad_oe_w   [2];
    logic        ready_w   [2];
    logic [15:0] addr_w    [2];
    logic        addr_io_w [2];
    logic        rd_req_w  [2];
    logic [7:0]  wdata_w   [2];
    logic        wr_stb_w  [2];
    logic        err_w     [2];

    int n_vec = 0;
    int n_err = 0;

    bus_demux85 #(.WAIT(0), .CW(4)) u_w0 (
        .clk(clk), .rstn(rstn), .ad_in(ad_in), .a_hi(a_hi), .ale(ale),
        .rd_n(rd_n), .wr_n(wr_n), .iom(iom), .rdata(rdata),
        .ad_out(ad_out_w[0]), .ad_oe(ad_oe_w[0]), .ready(ready_w[0]),
        .addr(addr_w[0]), .addr_io(addr_io_w[0]), .rd_req(rd_req_w[0]),
        .wdata(wdata_w[0]), .wr_stb(wr_stb_w[0]), .err(err_w[0])
    );

    bus_demux85 #(.WAIT(2), .CW(4)) u_w2 (
        .clk(clk), .rstn(rstn), .ad_in(ad_in), .a_hi(a_hi), .ale(ale),
        .rd_n(rd_n), .wr_n(wr_n), .iom(iom), .rdata(rdata),
        .ad_out(ad_out_w[1]), .ad_oe(ad_oe_w[1]), .ready(ready_w[1]),
        .addr(addr_w[1]), .addr_io(addr_io_w[1]), .rd_req(rd_req_w[1]),
        .wdata(wdata_w[1]), .wr_stb(wr_stb_w[1]), .err(err_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 address latched, 2 read, 3 write; age counts
    // clocks since the data phase began.
    int          m_phase [2];
    int          m_age   [2];
    logic [15:0] m_addr  [2];
    logic        m_io    [2];
    logic [7:0]  m_adout [2];
    logic        m_adoe  [2];
    logic        m_rdreq [2];
    logic [7:0]  m_wdata [2];
    logic        m_wrstb [2];
    logic        m_err   [2];

    function automatic int wait_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_age[i] = 0; m_addr[i] = '0; m_io[i] = 1'b0;
            m_adout[i] = '0; m_adoe[i] = 1'b0; m_rdreq[i] = 1'b0;
            m_wdata[i] = '0; m_wrstb[i] = 1'b0; m_err[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_wrstb[i] = 1'b0;
            m_err[i]   = 1'b0;
            if (ale) begin
                m_addr[i]  = {a_hi, ad_in};
                m_io[i]    = iom;
                m_phase[i] = 1;
                m_adoe[i]  = 1'b0;
                m_rdreq[i] = 1'b0;
`ifdef DEMUX_IO_MIRROR_EN
                if (iom) begin
                    m_addr[i] = {ad_in, ad_in};
                    m_err[i]  = (a_hi != ad_in);
                end
`endif
            end else if (m_phase[i] == 1) begin
                if (!rd_n && !wr_n) begin
                    m_err[i] = 1'b1; m_phase[i] = 0;
                end else if (!rd_n) begin
                    m_phase[i] = 2; m_age[i] = 0; m_rdreq[i] = 1'b1;
                end else if (!wr_n) begin
                    m_phase[i] = 3; m_age[i] = 0;
                end
            end else if (m_phase[i] == 2) begin
                if (rd_n) begin
                    m_phase[i] = 0; m_adoe[i] = 1'b0; m_rdreq[i] = 1'b0;
                end else begin
                    // Data flows once the programmed wait clocks have elapsed.
                    m_adoe[i] = (m_age[i] >= wait_of(i));
                    if (m_adoe[i]) m_adout[i] = rdata;
                    if (m_age[i] < 100) m_age[i]++;
                end
            end else if (m_phase[i] == 3) begin
                if (wr_n) begin
                    m_wrstb[i] = 1'b1; m_phase[i] = 0;
                end else begin
                    m_wdata[i] = ad_in;
                    if (m_age[i] < 100) m_age[i]++;
                end
            end
        end
    endtask

    // Every clock: advance the model, then compare both instances.
    always @(posedge clk) begin
        if (!rstn) model_reset();
        else       model_step();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ad_oe[%0d]", i),   16'(ad_oe_w[i]),   16'(m_adoe[i]));
            if (m_adoe[i]) chk($sformatf("ad_out[%0d]", i), 16'(ad_out_w[i]), 16'(m_adout[i]));
            chk($sformatf("ready[%0d]", i),
                16'(ready_w[i]),
                16'(!((m_phase[i] == 2 || m_phase[i] == 3) && m_age[i] < wait_of(i))));
            chk($sformatf("addr[%0d]", i),    addr_w[i],          m_addr[i]);
            chk($sformatf("addr_io[%0d]", i), 16'(addr_io_w[i]), 16'(m_io[i]));
            chk($sformatf("rd_req[%0d]", i),  16'(rd_req_w[i]),  16'(m_rdreq[i]));
            chk($sformatf("wdata[%0d]", i),   16'(wdata_w[i]),   16'(m_wdata[i]));
            chk($sformatf("wr_stb[%0d]", i),  16'(wr_stb_w[i]),  16'(m_wrstb[i]));
            chk($sformatf("err[%0d]", i),     16'(err_w[i]),     16'(m_err[i]));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_idle();
        ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic do_ale(input logic [7:0] hi, input logic [7:0] lo, input logic io);
        ale = 1'b1; a_hi = hi; ad_in = lo; iom = io;
        step();
        ale = 1'b0;
    endtask

    int low_cnt;
    int kind;
    int len;

    initial begin
        rstn = 1'b0; ad_in = '0; a_hi = '0; iom = 1'b0; rdata = '0;
        bus_idle();
        #1;
        chk("rst_ready", 16'(ready_w[1]), 16'h1);
        chk("rst_addr",  addr_w[1],       16'h0);
        chk("rst_ad_oe", 16'(ad_oe_w[1]), 16'h0);
        step();
        step();
        rstn = 1'b1;
        step();

        // Memory read, WAIT=0 instance
        do_ale(8'h12, 8'h34, 1'b0);
        chk("rd_addr",    addr_w[0],          16'h1234);
        chk("rd_addr_io", 16'(addr_io_w[0]), 16'h0);
        rd_n = 1'b0; rdata = 8'hA5;
        step();
        chk("rd_req_entry", 16'(rd_req_w[0]), 16'h1);
        chk("rd_oe_entry",  16'(ad_oe_w[0]),  16'h0);
        step();
        chk("rd_oe_2nd",  16'(ad_oe_w[0]),  16'h1);
        chk("rd_data",    16'(ad_out_w[0]), 16'h00A5);
        step();
        rd_n = 1'b1;
        step();
        chk("rd_oe_end",  16'(ad_oe_w[0]),  16'h0);
        chk("rd_req_end", 16'(rd_req_w[0]), 16'h0);

        // Memory write, WAIT=2 instance
        do_ale(8'h80, 8'h00, 1'b0);
        ad_in = 8'h5A; wr_n = 1'b0;
        low_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (ready_w[1] == 1'b0) low_cnt++;
        end
        chk("wr_wait_clocks", 16'(low_cnt), 16'd2);
        wr_n = 1'b1;
        step();
        chk("wr_stb",   16'(wr_stb_w[1]), 16'h1);
        chk("wr_wdata", 16'(wdata_w[1]),  16'h005A);
        chk("wr_addr",  addr_w[1],        16'h8000);
        step();
        chk("wr_stb_once", 16'(wr_stb_w[1]), 16'h0);

        // Simultaneous strobes
        do_ale(8'h33, 8'h44, 1'b0);
        rd_n = 1'b0; wr_n = 1'b0;
        step();
        chk("both_err",   16'(err_w[0]),    16'h1);
        chk("both_rdreq", 16'(rd_req_w[0]), 16'h0);
        bus_idle();
        step();
        chk("both_err_once", 16'(err_w[0]),    16'h0);
        chk("both_no_stb",   16'(wr_stb_w[0]), 16'h0);

        // Back-to-back: ALE during WR aborts the write
        do_ale(8'h11, 8'h22, 1'b0);
        ad_in = 8'h77; wr_n = 1'b0;
        step();
        step();
        ale = 1'b1; a_hi = 8'h9A; ad_in = 8'hBC;
        step();
        chk("b2b_addr",   addr_w[1],        16'h9ABC);
        chk("b2b_no_stb", 16'(wr_stb_w[1]), 16'h0);
        ale = 1'b0; wr_n = 1'b1;
        step();
        chk("b2b_no_stb2", 16'(wr_stb_w[1]), 16'h0);

        // IO cycle address handling
        do_ale(8'h41, 8'h40, 1'b1);
        chk("io_addr_io", 16'(addr_io_w[0]), 16'h1);
`ifdef DEMUX_IO_MIRROR_EN
        chk("io_addr", addr_w[0],      16'h4040);
        chk("io_err",  16'(err_w[0]),  16'h1);
`else
        chk("io_addr", addr_w[0],      16'h4140);
        chk("io_err",  16'(err_w[0]),  16'h0);
`endif
        iom = 1'b0;
        step();

        // Reset in the middle of a read with ad_oe asserted
        do_ale(8'hC0, 8'hDE, 1'b0);
        rd_n = 1'b0; rdata = 8'h3C;
        step();
        step();
        chk("mid_oe_pre", 16'(ad_oe_w[0]), 16'h1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_oe",    16'(ad_oe_w[0]),  16'h0);
        chk("mid_rst_rdreq", 16'(rd_req_w[0]), 16'h0);
        chk("mid_rst_addr",  addr_w[0],        16'h0);
        chk("mid_rst_ready", 16'(ready_w[1]),  16'h1);
        bus_idle();
        step();
        rstn = 1'b1;
        step();

        // Randomized bus cycles
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                // stray strobe with no ALE
                rd_n = 1'($urandom_range(0, 1)); wr_n = 1'($urandom_range(0, 1));
                rdata = 8'($urandom); ad_in = 8'($urandom);
                step();
                bus_idle();
            end
            do_ale(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                rdata = 8'($urandom);
                step();
            end
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 6);
            for (int c = 0; c < len; c++) begin
                rd_n  = !(kind <= 3 || kind == 8);
                wr_n  = !((kind >= 4 && kind <= 7) || kind == 8);
                ad_in = 8'($urandom);
                rdata = 8'($urandom);
                ale   = ($urandom_range(0, 14) == 0);
                if (ale) begin
                    a_hi = 8'($urandom);
                    iom  = ($urandom_range(0, 3) == 0);
                end
                step();
                ale = 1'b0;
            end
            bus_idle();
            for (int g = $urandom_range(1, 2); g > 0; g--) begin
                rdata = 8'($urandom);
                step();
            end
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_demux85.md
Name: bus_demux85

Overview:
- Bus-side responder for the 8085 multiplexed AD bus. It sits between the core's external bus pins and the memory/IO fabric.
- Demultiplexes AD[7:0] into a latched 16-bit address using ALE.
- Tracks the read/write machine cycle and inserts programmable wait states via READY.
- Returns read data onto the AD bus and issues a single-cycle write strobe with the captured write data.

Parameters:
- WAIT, 0, number of wait-state clocks (0..15) held with ready=0 at the start of every RD/WR phase.
- CW, 4, wait counter width; WAIT must be less than 2**CW.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- ad_in  input  8  AD bus sampled from pins.
- a_hi  input  8  A15..A8 from pins.
- ale  input  1  address latch enable, active high.
- rd_n  input  1  read strobe, active low.
- wr_n  input  1  write strobe, active low.
- iom  input  1  IO/M; 1 = IO cycle.
- rdata  input  8  read data from fabric, valid while rd_req=1.
- ad_out  output  8  data driven toward AD pins.
- ad_oe  output  1  AD output enable.
- ready  output  1  8085 READY; 0 inserts a wait state.
- addr  output  16  latched address.
- addr_io  output  1  latched IO/M of current cycle.
- rd_req  output  1  fabric read request.
- wdata  output  8  captured write data.
- wr_stb  output  1  one-cycle write strobe.
- err  output  1  one-cycle protocol error pulse.

Behaviour:
- Reset (async, rstn=0) sets every output and register to zero, except ready=1. State goes to IDLE.
- States: IDLE, ADDR, RD, WR.
- ALE handling, from any state: a sampled ale=1 sets addr<={a_hi,ad_in}, addr_io<=iom, wait counter<=WAIT, and the state to ADDR.
  - ALE in RD or WR aborts that cycle: ad_oe and rd_req drop the next cycle and no wr_stb is issued.
- ADDR:
  - rd_n=0 and wr_n=1: go to RD.
  - wr_n=0 and rd_n=1: go to WR.
  - rd_n=0 and wr_n=0: pulse err for one cycle and go to IDLE.
  - Otherwise stay in ADDR.
- RD:
  - rd_req=1 throughout the state.
  - While counter>0: ready=0, counter decrements each clock, ad_oe=0.
  - When counter=0: ready=1, ad_oe=1, ad_out<=rdata, registered every cycle.
  - rd_n sampled 1: go to IDLE next cycle, with ad_oe=0 and rd_req=0.
- WR:
  - ready=0 while counter>0, same counting as RD.
  - wdata<=ad_in on every cycle with wr_n=0.
  - On the first cycle wr_n is sampled 1: pulse wr_stb=1 for one cycle and go to IDLE. wdata holds the last value sampled while wr_n=0 and stays stable until the next write.
- WAIT=0: ready never drops. ad_oe asserts on the clock after RD entry, giving a read latency of 1 clock from the sampled rd_n=0.
- Timing: ready is combinational from state and counter. All other outputs are registered.
- In IDLE, strobes without a preceding ALE are ignored; no output changes.
- addr holds its value until the next ALE.

Optional Feature:
- Macro: DEMUX_IO_MIRROR_EN.
- Defined: for IO cycles (iom=1 at ALE), addr<={ad_in,ad_in}, which mirrors the port number into both bytes as the 8085 does. Additionally, if a_hi!=ad_in at ALE, err pulses one cycle; the cycle still proceeds.
- Undefined: addr<={a_hi,ad_in} for all cycles and no IO mismatch check.

Test Plan:
- Memory read with WAIT=0: ale with a_hi=0x12, ad_in=0x34, then rd_n=0 for 3 clocks with rdata=0xA5. Expect addr=0x1234, addr_io=0, rd_req=1, ad_oe=1 and ad_out=0xA5 from the second RD clock, ready always 1, ad_oe=0 after rd_n=1.
- Memory write with WAIT=2: ale at addr 0x8000, wr_n=0 for 4 clocks with ad_in=0x5A. Expect ready=0 for exactly 2 clocks, then wr_stb=1 for one clock after wr_n rises, wdata=0x5A.
- Simultaneous strobes: ale, then rd_n=0 and wr_n=0 together. Expect err=1 for one cycle, state IDLE, no rd_req or wr_stb.
- Reset mid-read: assert rstn=0 during RD with ad_oe=1. Expect ad_oe=0, rd_req=0, addr=0 and ready=1 immediately, with no clock needed.
- IO mirror (macro on): ale with iom=1, ad_in=0x40, a_hi=0x41. Expect addr=0x4040, addr_io=1, err pulse. With the macro off: addr=0x4140, no err.
- Back-to-back: second ale during WR with wr_n still 0. Expect no wr_stb, addr updated, state ADDR.
